// File: rtl/font_glyph_loader.sv
// font_glyph_loader: turns a byte stream of glyph bitmaps into font-RAM writes.
// Stream: start codepoint, glyph count (0 = 256), then rows glyph-major.
// Write address is {codepoint, row}, identical to the font reader's layout.
module font_glyph_loader #(
  parameter int unsigned FONT_HEIGHT = 16,
  parameter int unsigned FONT_WIDTH  = 8,
  parameter int unsigned N_CHARS     = 256
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [7:0]                                        in_data,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic                                              abort,
  output logic                                              wr_en,
  output logic [$clog2(N_CHARS)+$clog2(FONT_HEIGHT)-1:0]    wr_addr,
  output logic [FONT_WIDTH-1:0]                             wr_data,
  output logic                                              busy,
  output logic                                              done,
  output logic [8:0]                                        glyphs_written
);

  localparam int unsigned CW = $clog2(N_CHARS);
  localparam int unsigned RW = $clog2(FONT_HEIGHT);
  localparam int unsigned AW = CW + RW;
  localparam logic [RW-1:0] ROW_LAST = RW'(FONT_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cp_q, cp_d;
  logic [RW-1:0]   row_q, row_d;
  logic [8:0]      gcnt_q, gcnt_d;
  logic [8:0]      gtot_q, gtot_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [FONT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic            done_q, done_d;
  logic [8:0]      gw_q, gw_d;
  logic            accept;

  // Handshake and status derive from state only, so in_ready never depends on in_valid.
  always_comb begin
    in_ready = (state_q != S_DONE);
    busy     = (state_q != S_IDLE);
    accept   = in_valid && in_ready;
  end

  // Next-state, counters and registered write port; abort overrides any byte.
  always_comb begin
    state_d   = state_q;
    cp_d      = cp_q;
    row_d     = row_q;
    gcnt_d    = gcnt_q;
    gtot_d    = gtot_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    gw_d      = gw_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cp_d    = in_data[CW-1:0];
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          if (accept) begin
            gtot_d  = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            row_d   = '0;
            gcnt_d  = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cp_q, row_q};
            wr_data_d = in_data[FONT_WIDTH-1:0];
            row_d     = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
              cp_d   = cp_q + 1'b1;
              gcnt_d = gcnt_q + 9'd1;
              if ((gcnt_q + 9'd1) == gtot_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                gw_d    = gtot_q;
              end
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cp_q      <= '0;
      row_q     <= '0;
      gcnt_q    <= '0;
      gtot_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      gw_q      <= '0;
    end else begin
      state_q   <= state_d;
      cp_q      <= cp_d;
      row_q     <= row_d;
      gcnt_q    <= gcnt_d;
      gtot_q    <= gtot_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      gw_q      <= gw_d;
    end
  end

  // Output drive from registers.
  always_comb begin
    wr_en          = wr_en_q;
    wr_addr        = wr_addr_q;
    wr_data        = wr_data_q;
    done           = done_q;
    glyphs_written = gw_q;
  end

endmodule

// File: doc/font_glyph_loader.md
Name: font_glyph_loader

Overview:
- Write-side companion to the font ROM: accepts a byte stream of glyph bitmaps and drives the write port of a writable font RAM.
- Allows the text-mode renderer's font to be replaced at runtime, e.g. by CPU MMIO or a UART bootloader.
- Write addressing matches the read side exactly, {codepoint, row}, so the RAM can sit behind the same reader unchanged.

Parameters:
FONT_HEIGHT, 16, rows per glyph; power of two, 2..16
FONT_WIDTH, 8, bits per row; 1..8; row byte bits [FONT_WIDTH-1:0] are used, upper bits ignored
N_CHARS, 256, glyph count; power of two, 2..256

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  synchronous active-low reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte this cycle
abort  in  1  synchronous cancel of current transfer
wr_en  out  1  font RAM write strobe
wr_addr  out  $clog2(N_CHARS)+$clog2(FONT_HEIGHT)  {codepoint, row}
wr_data  out  FONT_WIDTH  bitmap row
busy  out  1  transfer in progress (not IDLE)
done  out  1  one-cycle pulse at transfer completion
glyphs_written  out  9  glyph count of last completed transfer

Behaviour:
- Byte accepted on a rising edge when in_valid && in_ready.
- Stream format: byte0 = start codepoint (low $clog2(N_CHARS) bits used); byte1 = glyph count G (0 means 256); then G*FONT_HEIGHT row bytes, glyph-major, row 0 first.
- Reset (rst_n=0 at an edge): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, glyphs_written=0, internal counters 0. in_ready=1 once out of reset.
- Reset mid-transfer: transfer is discarded and no further writes occur. Rows already written stay in the RAM.
- FSM states:
  - IDLE: in_ready=1. Accept byte0, latch codepoint, go to COUNT.
  - COUNT: in_ready=1. Accept byte1, latch G (0 becomes 256), row=0, glyph counter=0, go to DATA.
  - DATA: in_ready=1. For each accepted byte, register one write. Row increments 0..FONT_HEIGHT-1. At wrap, codepoint increments and glyph counter increments. After the last row of glyph G, go to DONE.
  - DONE: in_ready=0 for exactly one cycle. done=1, glyphs_written=G. Then go to IDLE.
- Write latency: wr_en is high exactly one cycle after the acceptance edge. wr_addr is {codepoint,row} at acceptance; wr_data is in_data[FONT_WIDTH-1:0]. wr_en is low otherwise. wr_addr/wr_data hold their last values when wr_en=0.
- Codepoint wraps N_CHARS-1 → 0 within a transfer.
- G > N_CHARS: later glyphs overwrite earlier ones per the wrap rule; not an error.
- in_valid gaps: counters hold and no write occurs; no timeout.
- busy=1 in COUNT, DATA and DONE.
- abort=1 at an edge: go to IDLE. done is not pulsed and glyphs_written is unchanged.
  - abort has priority over a simultaneous byte: the byte is dropped even though in_ready was high.
  - The registered write from a byte accepted on the previous edge still issues.
- No back-pressure from the RAM: writes are fire-and-forget, one per cycle maximum.

Test Plan:
- Reset, then stream 0x41, 0x01, then 16 bytes 0x00..0x0F at full rate → 16 writes at addr 0x410..0x41F with data 0x00..0x0F, each one cycle after acceptance. done pulses once, glyphs_written=1, in_ready=0 for one cycle.
- Stream 0xFF, 0x02, then 32 rows → writes at 0xFF0..0xFFF, then wrap to 0x000..0x00F. glyphs_written=2.
- Count byte 0x00 with 4096 rows (FONT_HEIGHT=16, N_CHARS=256) → all 4096 addresses written once, in order. glyphs_written=256.
- Randomised in_valid gaps, single glyph → same write sequence as the full-rate case; no write during gaps.
- abort asserted after 5 row bytes of glyph 0x20 → exactly 5 writes (0x200..0x204), busy=0 next cycle, no done. A following 0x30/0x01 transfer writes 0x300..0x30F.
- rst_n low for one edge after 3 row bytes, with in_valid held high → no writes after the pending one, all outputs at reset values. The next byte is treated as a start codepoint.
